// File: rtl/mod_pkg.sv
// mod_pkg: shared definitions for the modular-inverse datapath.
//   state_t   : sequencer states for mod_inv
//   OP_EXTRA  : cycles added to the operand width for each serial multiplier op
//   op_len    : total cycles for one reduce/mul/sqr op (width + OP_EXTRA)
//   msb_index : index of the highest set bit of a constant, for use at elaboration
package mod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_CHECK,
    ST_STEP,
    ST_MUL,
    ST_SQR,
    ST_DONE
  } state_t;

  // One launch cycle plus the multiplier's width+1 cycles.
  localparam int unsigned OP_EXTRA = 2;

  function automatic int unsigned op_len(input int unsigned w);
    return w + OP_EXTRA;
  endfunction

  function automatic int unsigned msb_index(input int unsigned v);
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) m = i;
    end
    return m;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial modular multiplier, r = x*y mod p.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   start : 1-cycle launch; x and y are captured on that edge
//   x     : multiplier, any width-bit value (scanned MSB first)
//   y     : multiplicand, must be < p
//   r     : result, valid while done=1
//   done  : 1-cycle pulse, width+1 cycles after start
module mod_mul_serial
  import mod_pkg::*;
#(
  parameter int unsigned p     = 37,
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] x,
  input  logic [width-1:0] y,
  output logic [width-1:0] r,
  output logic             done
);

  localparam int unsigned CW = $clog2(width + 1);
  localparam logic [width+1:0] PW = (width + 2)'(p);

  logic [width+1:0] r_acc;
  logic [width-1:0] r_x;
  logic [width-1:0] r_y;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [width+1:0] w_sum;
  logic [width+1:0] w_d1;
  logic [width+1:0] w_d2;

  // acc < p and y < p keep 2*acc + y below 3p, so two conditional
  // subtractions restore acc < p every step.
  always_comb begin
    w_sum = (r_acc << 1) + (r_x[width-1] ? {2'b00, r_y} : '0);
    w_d1  = (w_sum >= PW) ? (w_sum - PW) : w_sum;
    w_d2  = (w_d1  >= PW) ? (w_d1  - PW) : w_d1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_x    <= x;
        r_y    <= y;
        r_acc  <= '0;
        r_cnt  <= CW'(width);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_d2;
        r_x   <= r_x << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign r    = r_acc[width-1:0];
  assign done = r_done;

endmodule

// File: rtl/mod_inv.sv
// mod_inv: Fermat modular inverse, r = a^(p-2) mod p, by right-to-left
// square-and-multiply over one shared mod_mul_serial.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   enable   : level request; held high until done, drop to abort/release
//   a        : operand, any width-bit value, captured at start
//   r        : result, valid while done=1, held after release
//   done     : result valid, held while enable stays high
//   zero_div : with done, a = 0 mod p and r = 0
module mod_inv
  import mod_pkg::*;
#(
  parameter int unsigned p     = 37,
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [width-1:0] a,
  output logic [width-1:0] r,
  output logic             done,
  output logic             zero_div
);

  localparam int unsigned IW = $clog2(width);
  localparam logic [width-1:0] EV = width'(p - 2);
  localparam logic [IW-1:0] MSB_I = IW'(msb_index(p - 2));

  state_t           r_state;
  state_t           w_state_n;
  logic [width-1:0] r_a;
  logic [width-1:0] r_acc;
  logic [width-1:0] r_base;
  logic [IW-1:0]    r_idx;
  logic             r_zf;
  logic             r_pend;
  logic             r_busy;
  logic [width-1:0] r_r;
  logic             r_done;
  logic             r_zero;

  logic             w_start;
  logic             w_fin;
  logic             w_op;
  logic [width-1:0] w_mx;
  logic [width-1:0] w_my;
  logic [width-1:0] w_mr;
  logic             w_mdone;

  // STEP decision for bit i, resolved combinationally at an op boundary.
  function automatic state_t step_next(input logic [IW-1:0] i);
    if (EV[i])           return ST_MUL;
    else if (i < MSB_I)  return ST_SQR;
    else                 return ST_DONE;
  endfunction

  mod_mul_serial #(.p(p), .width(width)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .x     (w_mx),
    .y     (w_my),
    .r     (w_mr),
    .done  (w_mdone)
  );

  always_comb begin
    w_op = (r_state == ST_REDUCE) || (r_state == ST_MUL) || (r_state == ST_SQR);
    // r_pend holds off the first launch one cycle after capturing a.
    w_start = w_op && enable && !r_busy && !r_pend;
    // Only a completion of a launch from this run counts; a stale pulse
    // from an aborted run arrives while r_busy is low.
    w_fin = r_busy && w_mdone;
    w_mx = r_a;
    w_my = width'(1);
    case (r_state)
      ST_MUL: begin w_mx = r_acc;  w_my = r_base; end
      ST_SQR: begin w_mx = r_base; w_my = r_base; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    if (!enable && (r_state != ST_IDLE)) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (enable) w_state_n = ST_REDUCE;
        ST_REDUCE: if (w_fin) w_state_n = (w_mr == '0) ? ST_DONE : step_next('0);
        ST_MUL:    if (w_fin) w_state_n = (r_idx < MSB_I) ? ST_SQR : ST_DONE;
        ST_SQR:    if (w_fin) w_state_n = step_next(r_idx + 1'b1);
        ST_DONE:   w_state_n = ST_DONE;
        default:   w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_acc   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_zf    <= 1'b0;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_r     <= '0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= (r_state == ST_IDLE) && enable;
      if (w_state_n == ST_IDLE) r_busy <= 1'b0;
      else if (w_start)         r_busy <= 1'b1;
      else if (w_fin)           r_busy <= 1'b0;

      // Outputs are registered from DONE so they drop one cycle after enable.
      r_done <= (r_state == ST_DONE) && enable;
      r_zero <= (r_state == ST_DONE) && enable && r_zf;
      if ((r_state == ST_DONE) && enable) r_r <= r_zf ? '0 : r_acc;

      case (r_state)
        ST_IDLE: if (enable) begin
          r_a   <= a;
          r_acc <= width'(1);
          r_zf  <= 1'b0;
          r_idx <= '0;
        end
        ST_REDUCE: if (w_fin) begin
          r_base <= w_mr;
          r_zf   <= (w_mr == '0);
        end
        ST_MUL: if (w_fin) r_acc <= w_mr;
        ST_SQR: if (w_fin) begin
          r_base <= w_mr;
          r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r        = r_r;
  assign done     = r_done;
  assign zero_div = r_zero;

endmodule

// File: tb/tb_mod_inv.sv
module tb_mod_inv;

  localparam int unsigned P  = 37;
  localparam int unsigned W  = 32;
  localparam longint      PL = 37;
  localparam longint      WL = 32;
  localparam int          BOUND = 1000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] r;
  logic         done;
  logic         zero_div;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_inv #(.p(P), .width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .a        (a),
    .r        (r),
    .done     (done),
    .zero_div (zero_div)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inverse by repeated multiplication: a^(p-2) mod p.
  function automatic longint ref_inv(input longint av);
    longint b;
    longint res;
    b = av % PL;
    res = 1;
    if (b == 0) return 0;
    for (int k = 0; k < int'(PL) - 2; k++) res = (res * b) % PL;
    return res;
  endfunction

  function automatic longint ref_lat(input longint av);
    longint e;
    int pop;
    int msb;
    if (av % PL == 0) return 2 + (WL + 2);
    e = PL - 2;
    pop = 0;
    msb = 0;
    for (int i = 0; i < 32; i++) begin
      if (((e >> i) & 1) == 1) begin
        pop++;
        msb = i;
      end
    end
    return 2 + longint'(1 + pop + msb) * (WL + 2);
  endfunction

  // Raise enable, count cycles after the sampling edge until done; a is
  // scrambled while busy to confirm it was latched.
  task automatic run_op(input logic [W-1:0] av, output int lat);
    @(negedge clk);
    a = av;
    enable = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      a = W'($urandom());
    end while (!done && lat < BOUND);
  endtask

  task automatic release_op(input longint exp_r);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_held", done, 1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", done, 0);
    check("zd_clear", zero_div, 0);
    check("r_hold", r, exp_r);
  endtask

  task automatic full(input logic [W-1:0] av, input string tag);
    int lat;
    longint ar;
    ar = longint'(av);
    run_op(av, lat);
    check({tag, "_lat"}, lat, ref_lat(ar));
    check({tag, "_r"}, r, ref_inv(ar));
    check({tag, "_zd"}, zero_div, ((ar % PL) == 0) ? 1 : 0);
    if ((ar % PL) != 0) check({tag, "_prod"}, ((ar % PL) * longint'(r)) % PL, 1);
    release_op(ref_inv(ar));
  endtask

  logic [W-1:0] fa [7] = '{32'd123, 32'd1, 32'd2, 32'd36, 32'd39, 32'd0, 32'd74};
  longint       fr [7] = '{34, 1, 19, 36, 19, 0, 0};
  longint       fz [7] = '{0, 0, 0, 0, 0, 1, 1};
  longint       fl [7] = '{308, 308, 308, 308, 308, 36, 36};

  initial begin
    int lat;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_r", r, 0);
    check("rst_done", done, 0);
    check("rst_zd", zero_div, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(fa[i], lat);
      check("fix_lat", lat, fl[i]);
      check("fix_r", r, fr[i]);
      check("fix_zd", zero_div, fz[i]);
      release_op(fr[i]);
    end

    for (int v = 1; v < 37; v++) full(W'(v), "sweep");
    full('1, "max");
    repeat (12) full(W'($urandom()), "rand");

    // Abort mid-run: no done may appear.
    @(negedge clk);
    a = 32'd7;
    enable = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    run_op(32'd3, lat);
    check("abort_re_lat", lat, 308);
    check("abort_re_r", r, 25);
    release_op(25);

    // Asynchronous reset mid-run clears outputs at once (r was 25).
    @(negedge clk);
    a = 32'd9;
    enable = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_r", r, 0);
    check("arst_done", done, 0);
    check("arst_zd", zero_div, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(32'd5, lat);
    check("post_rst_lat", lat, 308);
    check("post_rst_r", r, 15);
    release_op(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
